// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared widths, opcodes, entry types and tag helpers for the reservation station
package reservation_station_pkg;

  localparam int DATA_WID     = 32;
  localparam int ADDR_WID     = 32;
  localparam int ROB_POS_WID  = 4;
  localparam int ROB_ID_WID   = 5;
  localparam int OPCODE_WID   = 7;
  localparam int FUNCT3_WID   = 3;
  localparam int RS_SIZE      = 16;
  localparam int RS_IDX_WID   = 4;
  localparam int TAG_PEND_BIT = 4;

  localparam logic [OPCODE_WID-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_WID-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_WID-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_WID-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_WID-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_WID-1:0] OP_ARITH  = 7'b0110011;
  localparam logic [OPCODE_WID-1:0] OP_ARITHI = 7'b0010011;

  typedef struct packed {
    logic [OPCODE_WID-1:0]  opcode;
    logic [FUNCT3_WID-1:0]  funct3;
    logic                   funct7;
    logic [DATA_WID-1:0]    val1;
    logic [DATA_WID-1:0]    val2;
    logic [DATA_WID-1:0]    imm;
    logic [ADDR_WID-1:0]    pc;
    logic [ROB_POS_WID-1:0] rob_pos;
  } alu_op_t;

  typedef struct packed {
    logic                  busy;
    logic [ROB_ID_WID-1:0] tag1;
    logic [ROB_ID_WID-1:0] tag2;
    alu_op_t               op;
  } rs_entry_t;

  function automatic logic tag_match(input logic [ROB_ID_WID-1:0] tag, input logic bc_valid,
                                     input logic [ROB_POS_WID-1:0] bc_pos);
    return bc_valid && tag[TAG_PEND_BIT] && (tag[ROB_POS_WID-1:0] == bc_pos);
  endfunction

  function automatic logic is_rs_opcode(input logic [OPCODE_WID-1:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_ARITH, OP_ARITHI};
  endfunction

endpackage

// File: rtl/rs_select.sv
// rtl/rs_select.sv - lowest-index priority encoder with a found flag
module rs_select #(
  parameter int N       = 16,
  parameter int IDX_WID = 4
) (
  input  logic [N-1:0]       req,
  output logic [IDX_WID-1:0] idx,
  output logic               found
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = i[IDX_WID-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - ALU reservation station with broadcast wake-up and in-order-index dispatch
// Optional RS_BYPASS_EN: a ready issue goes straight to the ALU when no stored entry is ready.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE    = reservation_station_pkg::RS_SIZE,
  parameter int RS_IDX_WID = reservation_station_pkg::RS_IDX_WID
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   rs_en,
  input  logic [ROB_POS_WID-1:0] issue_rob_pos,
  input  logic [OPCODE_WID-1:0]  issue_opcode,
  input  logic [FUNCT3_WID-1:0]  issue_funct3,
  input  logic                   issue_funct7,
  input  logic [DATA_WID-1:0]    issue_rs1_val,
  input  logic [ROB_ID_WID-1:0]  issue_rs1_rob_id,
  input  logic [DATA_WID-1:0]    issue_rs2_val,
  input  logic [ROB_ID_WID-1:0]  issue_rs2_rob_id,
  input  logic [DATA_WID-1:0]    issue_imm,
  input  logic [ADDR_WID-1:0]    issue_pc,
  output logic                   rs_full,
  input  logic                   alu_result,
  input  logic [ROB_POS_WID-1:0] alu_result_rob_pos,
  input  logic [DATA_WID-1:0]    alu_result_val,
  input  logic                   lsb_result,
  input  logic [ROB_POS_WID-1:0] lsb_result_rob_pos,
  input  logic [DATA_WID-1:0]    lsb_result_val,
  output logic                   alu_en,
  output logic [OPCODE_WID-1:0]  alu_opcode,
  output logic [FUNCT3_WID-1:0]  alu_funct3,
  output logic                   alu_funct7,
  output logic [DATA_WID-1:0]    alu_val1,
  output logic [DATA_WID-1:0]    alu_val2,
  output logic [DATA_WID-1:0]    alu_imm,
  output logic [ADDR_WID-1:0]    alu_pc,
  output logic [ROB_POS_WID-1:0] alu_rob_pos
);

  // One slot of slack is kept for the instruction already leaving the decoder.
  localparam logic [RS_IDX_WID:0] FULL_THRESH = (RS_IDX_WID + 1)'(RS_SIZE - 1);

  rs_entry_t             ent_q [RS_SIZE];
  rs_entry_t             ent_d [RS_SIZE];
  alu_op_t               alu_q, alu_d;
  logic                  alu_en_q, alu_en_d;
  logic                  rs_full_q, rs_full_d;

  logic [RS_SIZE-1:0]    free_req, ready_req;
  logic [RS_IDX_WID-1:0] free_idx, ready_idx;
  logic                  free_found, ready_found;
  rs_entry_t             in_ent;
  logic                  in_ready;
  logic                  bypass;
  logic [RS_IDX_WID:0]   busy_cnt;

  always_comb begin
    free_req  = '0;
    ready_req = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_req[i]  = !ent_q[i].busy;
      ready_req[i] = ent_q[i].busy && (ent_q[i].tag1 == '0) && (ent_q[i].tag2 == '0);
    end
  end

  rs_select #(.N(RS_SIZE), .IDX_WID(RS_IDX_WID)) u_free_sel (
    .req   (free_req),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_select #(.N(RS_SIZE), .IDX_WID(RS_IDX_WID)) u_ready_sel (
    .req   (ready_req),
    .idx   (ready_idx),
    .found (ready_found)
  );

  // Incoming operands see this cycle's broadcasts so they never miss a result.
  always_comb begin
    in_ent            = '0;
    in_ent.busy       = 1'b1;
    in_ent.op.opcode  = issue_opcode;
    in_ent.op.funct3  = issue_funct3;
    in_ent.op.funct7  = issue_funct7;
    in_ent.op.val1    = issue_rs1_val;
    in_ent.op.val2    = issue_rs2_val;
    in_ent.op.imm     = issue_imm;
    in_ent.op.pc      = issue_pc;
    in_ent.op.rob_pos = issue_rob_pos;
    in_ent.tag1       = issue_rs1_rob_id[TAG_PEND_BIT] ? issue_rs1_rob_id : '0;
    in_ent.tag2       = issue_rs2_rob_id[TAG_PEND_BIT] ? issue_rs2_rob_id : '0;
    if (tag_match(in_ent.tag1, alu_result, alu_result_rob_pos)) begin
      in_ent.op.val1 = alu_result_val;
      in_ent.tag1    = '0;
    end else if (tag_match(in_ent.tag1, lsb_result, lsb_result_rob_pos)) begin
      in_ent.op.val1 = lsb_result_val;
      in_ent.tag1    = '0;
    end
    if (tag_match(in_ent.tag2, alu_result, alu_result_rob_pos)) begin
      in_ent.op.val2 = alu_result_val;
      in_ent.tag2    = '0;
    end else if (tag_match(in_ent.tag2, lsb_result, lsb_result_rob_pos)) begin
      in_ent.op.val2 = lsb_result_val;
      in_ent.tag2    = '0;
    end
    in_ready = (in_ent.tag1 == '0) && (in_ent.tag2 == '0);
  end

  always_comb begin
    ent_d    = ent_q;
    alu_d    = alu_q;
    alu_en_d = 1'b0;
    bypass   = 1'b0;
    busy_cnt = '0;
    if (rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_d[i].busy = 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy) begin
          if (tag_match(ent_q[i].tag1, alu_result, alu_result_rob_pos)) begin
            ent_d[i].op.val1 = alu_result_val;
            ent_d[i].tag1    = '0;
          end else if (tag_match(ent_q[i].tag1, lsb_result, lsb_result_rob_pos)) begin
            ent_d[i].op.val1 = lsb_result_val;
            ent_d[i].tag1    = '0;
          end
          if (tag_match(ent_q[i].tag2, alu_result, alu_result_rob_pos)) begin
            ent_d[i].op.val2 = alu_result_val;
            ent_d[i].tag2    = '0;
          end else if (tag_match(ent_q[i].tag2, lsb_result, lsb_result_rob_pos)) begin
            ent_d[i].op.val2 = lsb_result_val;
            ent_d[i].tag2    = '0;
          end
        end
      end
      if (ready_found) begin
        alu_en_d               = 1'b1;
        alu_d                  = ent_q[ready_idx].op;
        ent_d[ready_idx].busy  = 1'b0;
      end
`ifdef RS_BYPASS_EN
      bypass = rs_en && in_ready && !ready_found;
`else
      bypass = 1'b0;
`endif
      if (bypass) begin
        alu_en_d = 1'b1;
        alu_d    = in_ent.op;
      end else if (rs_en && free_found) begin
        ent_d[free_idx] = in_ent;
      end
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_cnt = busy_cnt + {{RS_IDX_WID{1'b0}}, ent_d[i].busy};
    end
    rs_full_d = !rollback && (busy_cnt >= FULL_THRESH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      alu_q     <= '0;
      alu_en_q  <= 1'b0;
      rs_full_q <= 1'b0;
    end else if (rdy) begin
      ent_q     <= ent_d;
      alu_q     <= alu_d;
      alu_en_q  <= alu_en_d;
      rs_full_q <= rs_full_d;
    end
  end

  assign rs_full     = rs_full_q;
  assign alu_en      = alu_en_q;
  assign alu_opcode  = alu_q.opcode;
  assign alu_funct3  = alu_q.funct3;
  assign alu_funct7  = alu_q.funct7;
  assign alu_val1    = alu_q.val1;
  assign alu_val2    = alu_q.val2;
  assign alu_imm     = alu_q.imm;
  assign alu_pc      = alu_q.pc;
  assign alu_rob_pos = alu_q.rob_pos;

  // An issue with no free slot is dropped; the decoder must honour rs_full.
  a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
    !(rdy && !rollback && rs_en && !bypass && !free_found));

  a_issue_opcode: assert property (@(posedge clk) disable iff (rst)
    !(rdy && rs_en) || is_rs_opcode(issue_opcode));

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Consumer end of the decoder issue interface for ALU, branch, JAL/JALR, LUI and AUIPC instructions.
- Buffers issued instructions together with their operand values or pending ROB tags.
- Wakes pending operands by snooping the ALU and LSB result broadcasts.
- Dispatches one ready instruction per cycle to the ALU; sits between decoder/ROB and the ALU.

Parameters:
RS_SIZE, 16, number of entries; power of two.
RS_IDX_WID, 4, log2(RS_SIZE).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; low freezes all state
rollback  in  1  mispredict flush
rs_en  in  1  issue valid from decoder
issue_rob_pos  in  4  destination ROB position
issue_opcode  in  7  opcode
issue_funct3  in  3  funct3
issue_funct7  in  1  inst[30]
issue_rs1_val  in  32  operand 1 value
issue_rs1_rob_id  in  5  operand 1 tag; bit4=1 means pending, bits[3:0]=ROB pos
issue_rs2_val  in  32  operand 2 value
issue_rs2_rob_id  in  5  operand 2 tag, same encoding
issue_imm  in  32  immediate
issue_pc  in  32  instruction pc
rs_full  out  1  registered stall to fetcher
alu_result  in  1  ALU broadcast valid
alu_result_rob_pos  in  4  ALU broadcast tag
alu_result_val  in  32  ALU broadcast value
lsb_result  in  1  LSB broadcast valid
lsb_result_rob_pos  in  4  LSB broadcast tag
lsb_result_val  in  32  LSB broadcast value
alu_en  out  1  dispatch valid, one cycle
alu_opcode  out  7 / alu_funct3 out 3 / alu_funct7 out 1  dispatched op
alu_val1  out  32 / alu_val2 out 32 / alu_imm out 32 / alu_pc out 32  dispatched operands
alu_rob_pos  out  4  dispatched ROB position

Behaviour:
- Reset (async, rst high): all entries invalid; alu_en=0; rs_full=0; every alu_* output 0.
- rdy low: no state changes; outputs hold their values.
- Entry fields: busy, op fields, val1/val2, tag1/tag2 (5-bit, 0 = ready), imm, pc, rob_pos.
- Issue (rs_en=1): writes the lowest-index free entry at the clock edge.
  - Operand tags are first resolved against the same-cycle broadcasts (match on bit4=1 and bits[3:0]==rob_pos).
  - A matching tag captures the broadcast value and clears the tag to 0.
- Wake-up: every busy entry with a pending tag matching a valid broadcast captures the value and clears the tag at the edge. ALU and LSB may both wake entries in the same cycle, including the same entry on different operands.
- Select and dispatch:
  - Uses registered state only.
  - Picks the lowest-index entry with busy=1, tag1=0 and tag2=0.
  - At the edge: alu_en=1, alu_* carry that entry's fields, and the entry's busy bit is cleared.
  - With no ready entry: alu_en=0 and alu_* hold their last values.
- Minimum latency issue to alu_en: 2 cycles, i.e. written at edge N, selected in the following cycle, alu_en high after edge N+1.
- Simultaneous issue and dispatch in one cycle: both happen. The freed slot is not reused until the next cycle.
- rs_full: registered; set when the next-state busy count is ≥ RS_SIZE-1. This leaves one slot of slack for the instruction already in flight from the decoder.
- Issue while every entry is busy is a protocol violation. It is flagged by an assertion and the issue is dropped.
- Rollback (rdy=1): at the edge, all busy bits clear, alu_en=0 and rs_full=0. Rollback wins over a same-cycle issue, wake-up or dispatch.
- Tags are 4-bit ROB positions. Wrap-around aliasing cannot occur because the ROB never reuses a position while a consumer is pending.

Optional Feature:
RS_BYPASS_EN
- Defined: when rs_en=1, both incoming operands are ready after broadcast resolution, and no stored entry is ready, the instruction is not allocated. It is driven onto alu_* with alu_en=1 at the next edge, giving 1-cycle latency.
- Undefined: every issue is allocated; minimum latency is 2 cycles.

Decomposition:
- Shared defines header holds: DATA_WID, ADDR_WID, ROB_POS_WID, ROB_ID_WID, OPCODE/FUNCT3 widths, opcode constants, RS_SIZE, and the tag-pending bit index (4).
- Sub-module rs_select: a parameterised lowest-index priority encoder with a found flag. It is instantiated twice, once for the free slot and once for the ready entry.

Test Plan:
- Ready issue: ADDI with rs1_rob_id=0, val1=5, imm=3, rob_pos=2 → alu_en high 2 cycles later (1 with RS_BYPASS_EN); alu_val1=5, alu_imm=3, alu_rob_pos=2.
- Wake-up: ADD with tag1=0x13 issued; 3 cycles later alu_result=1, pos=3, val=0x55 → alu_en the cycle after next, alu_val1=0x55.
- Same-cycle broadcast: issue with tag2=0x17 while lsb_result=1, pos=7, val=9 → dispatched with alu_val2=9, with no further wake-up needed.
- Fill: 15 pending issues → rs_full high after edge 15; one dispatch later → rs_full deasserts.
- Rollback: 4 entries busy; rollback pulse → next cycle alu_en=0, rs_full=0; later broadcasts cause no dispatch.
- Ordering: entries 0 and 5 both become ready in the same cycle → entry 0 dispatched first, entry 5 on the following cycle.
